// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier for signed or unsigned WIDTH-bit
// operands. One Booth digit is retired per clock; the result is published
// in a single write when the last digit has been accumulated.
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_sig,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done_sig,
  output logic               busy,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  // Operands carry two extra bits so unsigned values stay positive when
  // treated as two's complement and the digit count is the same for both modes.
  localparam int EW   = WIDTH + 2;
  // Upper half has headroom for +-2*A on top of the running partial sum.
  localparam int HW   = WIDTH + 4;
  // {upper half, multiplier, appended B[-1]}
  localparam int PW   = HW + EW + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic signed [EW-1:0]   r_a;
  logic signed [PW-1:0]   r_acc;
  logic                   r_done;
  logic                   r_busy;
  logic [2*WIDTH-1:0]     r_product;

  logic signed [HW-1:0]   w_hi;
  logic signed [PW-1:0]   w_sum;
  logic signed [PW-1:0]   w_next;

  function automatic logic signed [EW-1:0] ext_op(input logic [WIDTH-1:0] v,
                                                  input logic sm);
    ext_op = {{2{sm & v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [HW-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic signed [EW-1:0] a);
    logic signed [HW-1:0] a1;
    a1 = {{(HW-EW){a[EW-1]}}, a};
    case (trip)
      3'b001, 3'b010: booth_pp = a1;
      3'b011:         booth_pp = a1 <<< 1;
      3'b100:         booth_pp = -(a1 <<< 1);
      3'b101, 3'b110: booth_pp = -a1;
      default:        booth_pp = '0;
    endcase
  endfunction

  // One Booth step: add the recoded partial product into the upper half, then shift by two.
  always_comb begin
    w_hi   = r_acc[PW-1 -: HW] + booth_pp(r_acc[2:0], r_a);
    w_sum  = {w_hi, r_acc[EW:0]};
    w_next = w_sum >>> 2;
  end

  // Control FSM with registered outputs; product is written only on the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start_sig) begin
            r_a     <= ext_op(A, signed_mode);
            r_acc   <= {{HW{1'b0}}, ext_op(B, signed_mode), 1'b0};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_product <= w_next[2*WIDTH:1];
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done_sig = r_done;
  assign busy     = r_busy;
  assign product  = r_product;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier (WIDTH=8): hand-computed
// products, latency, busy length, pulse counts and reset behaviour.
module tb_booth_radix4_multiplier;

  localparam int WIDTH = 8;
  localparam int ITER  = WIDTH / 2 + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_sig;
  logic               signed_mode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               done_sig;
  logic               busy;
  logic [2*WIDTH-1:0] product;

  int checks   = 0;
  int failures = 0;

  booth_radix4_multiplier #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_sig   (start_sig),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .done_sig    (done_sig),
    .busy        (busy),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE and observe it at negedges.
  // k=1 is the cycle after the launch edge; done is expected at k=ITER+1.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit sm,
                       input logic [15:0] exp, input string tag, input bit scramble);
    int done_at;
    int pulses;
    int busy_cnt;
    bit stable_ok;
    logic [15:0] prev;
    done_at   = 0;
    pulses    = 0;
    busy_cnt  = 0;
    stable_ok = 1'b1;
    @(negedge clk);
    prev        = product;
    A           = a;
    B           = b;
    signed_mode = sm;
    start_sig   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_sig) begin
        pulses++;
        if (done_at == 0) done_at = k;
      end
      if (busy) busy_cnt++;
      if (k <= ITER && product !== prev) stable_ok = 1'b0;
      if (scramble && k <= ITER + 1) begin
        A           = 8'($urandom);
        B           = 8'($urandom);
        signed_mode = 1'($urandom);
        start_sig   = (k <= ITER) ? k[0] : 1'b1;
      end else begin
        start_sig = 1'b0;
      end
    end
    check({tag, "_latency"}, done_at, ITER + 1);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_busy_cycles"}, busy_cnt, ITER + 1);
    check({tag, "_held_during_calc"}, {31'd0, stable_ok}, 32'd1);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    int pulse_k[$];
    int n_done;
    bit hold_ok;
    rst         = 1'b0;
    start_sig   = 1'b0;
    signed_mode = 1'b0;
    A           = '0;
    B           = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done_sig}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);

    // Release just after an edge so the next rising edge is the launch edge
    @(posedge clk);
    #2 rst = 1'b1;
    do_op(8'd2,   8'd4,   1'b1, 16'h0008, "s_2x4", 1'b0);
    do_op(8'hFC,  8'd4,   1'b1, 16'hFFF0, "s_m4x4", 1'b0);
    do_op(8'hFC,  8'd4,   1'b0, 16'h03F0, "u_252x4", 1'b0);
    do_op(8'd127, 8'h81,  1'b1, 16'hC0FF, "s_127xm127", 1'b0);
    do_op(8'h81,  8'd127, 1'b1, 16'hC0FF, "s_m127x127", 1'b0);
    do_op(8'h80,  8'h80,  1'b1, 16'h4000, "s_min_sq", 1'b0);
    do_op(8'hFF,  8'hFF,  1'b0, 16'hFE01, "u_max_sq", 1'b0);
    do_op(8'h80,  8'd2,   1'b0, 16'h0100, "u_128x2", 1'b0);
    do_op(8'h00,  8'h5A,  1'b1, 16'h0000, "s_zero", 1'b0);
    do_op(8'h00,  8'hFF,  1'b0, 16'h0000, "u_zero", 1'b0);
    do_op(8'd3,   8'd5,   1'b1, 16'h000F, "scramble_3x5", 1'b1);

    // Reset during the third CALC cycle aborts the operation
    @(negedge clk);
    A = 8'd9; B = 8'd9; signed_mode = 1'b1; start_sig = 1'b1;
    @(negedge clk);
    start_sig = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_done", {31'd0, done_sig}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_sig) n_done++;
    end
    check("abort_no_pulse", n_done, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    do_op(8'd6, 8'd7, 1'b1, 16'h002A, "after_abort_6x7", 1'b0);

    // start_sig held high: one operation every ITER+2 cycles
    @(negedge clk);
    A = 8'd5; B = 8'd9; signed_mode = 1'b1; start_sig = 1'b1;
    hold_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_sig) pulse_k.push_back(k);
      if (k >= ITER + 1 && product !== 16'h002D) hold_ok = 1'b0;
    end
    start_sig = 1'b0;
    check("hold_pulse_count", pulse_k.size(), 4);
    if (pulse_k.size() >= 1) check("hold_first_pulse", pulse_k[0], ITER + 1);
    for (int i = 1; i < pulse_k.size(); i++)
      check("hold_period", pulse_k[i] - pulse_k[i-1], ITER + 2);
    check("hold_product_stable", {31'd0, hold_ok}, 32'd1);
    repeat (12) @(negedge clk);
    check("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (even, >= 4).
REQ-002 The block SHALL have derived constant ITER = WIDTH/2 + 1, meaning radix-4 iteration count.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port start_sig  input  1  request; level, sampled only in IDLE.
REQ-006 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at launch.
REQ-007 Port A  input  WIDTH  multiplicand; sampled at launch.
REQ-008 Port B  input  WIDTH  multiplier; sampled at launch.
REQ-009 Port done_sig  output  1  result-valid pulse, high exactly one cycle per operation.
REQ-010 Port busy  output  1  high while in CALC or DONE.
REQ-011 Port product  output  2*WIDTH  result, registered.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start_sig=1 at an edge SHALL latch A, B, signed_mode, clear the accumulator and iteration counter, and enter CALC (launch edge).
REQ-014 IDLE with start_sig=0 SHALL remain in IDLE; product holds its value.
REQ-015 Operands SHALL be extended internally to WIDTH+2 bits: sign-extension if signed_mode=1, zero-extension if 0.
REQ-016 CALC SHALL perform one radix-4 Booth step per cycle: recode triplet {B[2i+1],B[2i],B[2i-1]} (B[-1]=0) to 0, +-1*A, +-2*A, add into accumulator, then arithmetic-shift right by 2.
REQ-017 CALC SHALL last exactly ITER cycles (5 for WIDTH=8) for both modes; no early termination on zero operands.
REQ-018 On the edge ending the last CALC cycle, the block SHALL write product = low 2*WIDTH bits of the exact product and enter DONE.
REQ-019 DONE SHALL assert done_sig for one cycle and return to IDLE on the next edge regardless of start_sig.
REQ-020 Latency: done_sig SHALL be high in the cycle starting ITER+1 edges after the launch edge; next launch possible one edge after done_sig falls.
REQ-021 start_sig, A, B, signed_mode changes during CALC or DONE SHALL be ignored.
REQ-022 A start_sig held high through DONE SHALL launch a new operation on the first IDLE edge, with the operands present at that edge.
REQ-023 product SHALL hold the last result until the next DONE entry; it is never partially updated.
REQ-024 Results SHALL be exact for all inputs, including signed -2^(WIDTH-1) x -2^(WIDTH-1) and unsigned (2^WIDTH-1)^2.
REQ-025 Signed result SHALL be two's-complement in 2*WIDTH bits; unsigned result SHALL be zero-extended magnitude.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, done_sig=0, busy=0, product=0, and clear accumulator, counter and latched operands.
REQ-027 rst asserted mid-CALC or in DONE SHALL abort the operation with no done_sig pulse; after release, block waits in IDLE for start_sig.
REQ-028 First launch SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-029 signed_mode=1, A=2, B=4, start_sig held -> done_sig one cycle, ITER+1=6 edges after launch, product=16'h0008.
REQ-030 signed_mode=1, A=8'hFC, B=4 -> product=16'hFFF0; then A=127, B=8'h81 -> product=16'hC0FF; then A=8'h81, B=127 -> 16'hC0FF.
REQ-031 Corners: signed A=B=8'h80 -> 16'h4000; unsigned A=B=8'hFF -> 16'hFE01; unsigned A=8'h80, B=2 -> 16'h0100; A=0 any B -> 16'h0000, same latency.
REQ-032 Launch A=3, B=5 signed, change A/B/signed_mode/start_sig every cycle during CALC -> product=16'h000F, single done_sig pulse, busy high 6 cycles.
REQ-033 Assert rst on 3rd CALC cycle -> done_sig never pulses, product=0, busy=0 immediately; after release, launch A=6, B=7 -> product=16'h002A.
REQ-034 start_sig held high continuously with constant operands -> done_sig pulses every 7 cycles, product stable between pulses.
